// File: rtl/lut_coef_loader.sv
// Streams DEPTH coefficient words into one LUT port, then reads the table back
// and checks its modular sum before releasing the port with done or error.
module lut_coef_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3584,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] lut_address,
    output logic [DATA_WIDTH-1:0] lut_data,
    output logic                  lut_wren,
    output logic                  lut_rden,
    input  logic [DATA_WIDTH-1:0] lut_q,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         wrCount_q;
    logic [CW-1:0]         rdCount_q;
    logic [CW-1:0]         capCount_q;
    logic [DATA_WIDTH-1:0] loadSum_q;
    logic [DATA_WIDTH-1:0] rbSum_q;
    logic [DATA_WIDTH-1:0] rbSum_d;
    logic [ADDR_WIDTH-1:0] lutAddress_q;
    logic [DATA_WIDTH-1:0] lutData_q;
    logic                  lutWren_q;
    logic                  lutRden_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [RD_LAT-1:0]     rdValid_q;
    logic                  capture;

    // The final compare must include the word being captured on this edge.
    assign rbSum_d  = rbSum_q + lut_q;
    assign capture  = rdValid_q[RD_LAT-1];

    assign in_ready    = (state_q == S_LOAD);
    assign lut_address = lutAddress_q;
    assign lut_data    = lutData_q;
    assign lut_wren    = lutWren_q;
    assign lut_rden    = lutRden_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign checksum    = loadSum_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wrCount_q    <= '0;
            rdCount_q    <= '0;
            capCount_q   <= '0;
            loadSum_q    <= '0;
            rbSum_q      <= '0;
            lutAddress_q <= '0;
            lutData_q    <= '0;
            lutWren_q    <= 1'b0;
            lutRden_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            rdValid_q    <= '0;
        end else begin
            rdValid_q <= (rdValid_q << 1) | RD_LAT'(lutRden_q);
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        wrCount_q  <= '0;
                        rdCount_q  <= '0;
                        capCount_q <= '0;
                        loadSum_q  <= '0;
                        rbSum_q    <= '0;
                        lutWren_q  <= 1'b0;
                        lutRden_q  <= 1'b0;
                        rdValid_q  <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        lutAddress_q <= ADDR_WIDTH'(wrCount_q);
                        lutData_q    <= in_data;
                        lutWren_q    <= 1'b1;
                        loadSum_q    <= loadSum_q + in_data;
                        wrCount_q    <= wrCount_q + 1'b1;
                        if (wrCount_q == CW'(DEPTH - 1)) begin
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        lutWren_q <= 1'b0;
                    end
                end
                // The last write occupies the port here, so reads start one cycle later.
                S_DRAIN: begin
                    lutWren_q    <= 1'b0;
                    lutRden_q    <= 1'b1;
                    lutAddress_q <= '0;
                    rdCount_q    <= CW'(1);
                    state_q      <= S_VERIFY;
                end
                S_VERIFY: begin
                    if (rdCount_q == CW'(DEPTH)) begin
                        lutRden_q <= 1'b0;
                    end else begin
                        lutAddress_q <= ADDR_WIDTH'(rdCount_q);
                        rdCount_q    <= rdCount_q + 1'b1;
                    end
                    if (capture) begin
                        rbSum_q    <= rbSum_d;
                        capCount_q <= capCount_q + 1'b1;
                        if (capCount_q == CW'(DEPTH - 1)) begin
                            busy_q <= 1'b0;
                            if (rbSum_d == loadSum_q) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_ERROR;
                                error_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_coef_loader.sv
// Drives two loaders (read latency 1 and 2) from one word stream against
// behavioural RAMs and checks them against a cycle-level model of the load/verify sequence.
module tb_lut_coef_loader;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 32;

    logic          clock;
    logic          rstN;
    logic          start;
    logic [DW-1:0] inData;
    logic          inValid;
    logic          faultEn;

    logic          inReadyA, wrenA, rdenA, busyA, doneA, errorA;
    logic [AW-1:0] addrA;
    logic [DW-1:0] dataA, qA, checksumA;
    logic          inReadyB, wrenB, rdenB, busyB, doneB, errorB;
    logic [AW-1:0] addrB;
    logic [DW-1:0] dataB, qB, q1B, checksumB;

    logic [DW-1:0] memA [0:DEPTH-1];
    logic [DW-1:0] memB [0:DEPTH-1];
    logic [DW-1:0] words [0:DEPTH-1];

    int checkCount;
    int passCount;

    lut_coef_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LAT(1)) dutA (
        .clock(clock), .rst_n(rstN), .start(start), .in_data(inData), .in_valid(inValid),
        .in_ready(inReadyA), .lut_address(addrA), .lut_data(dataA), .lut_wren(wrenA),
        .lut_rden(rdenA), .lut_q(qA), .busy(busyA), .done(doneA), .error(errorA),
        .checksum(checksumA)
    );

    lut_coef_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LAT(2)) dutB (
        .clock(clock), .rst_n(rstN), .start(start), .in_data(inData), .in_valid(inValid),
        .in_ready(inReadyB), .lut_address(addrB), .lut_data(dataB), .lut_wren(wrenB),
        .lut_rden(rdenB), .lut_q(qB), .busy(busyB), .done(doneB), .error(errorB),
        .checksum(checksumB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural single-port RAMs; the fault flips bit 0 of address 3 on readback.
    always @(posedge clock) begin
        if (wrenA) memA[addrA] <= dataA;
        qA <= rdenA ? (memA[addrA] ^ ((faultEn && addrA == 3'd3) ? 32'd1 : 32'd0)) : '0;
        if (wrenB) memB[addrB] <= dataB;
        q1B <= rdenB ? (memB[addrB] ^ ((faultEn && addrB == 3'd3) ? 32'd1 : 32'd0)) : '0;
        qB  <= q1B;
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One complete load/verify run. validMode: 0 back-to-back, 1 toggling, 2 random.
    task automatic applyStimulus(input int validMode, input bit fault, input int midStart,
                                 input bit abortVerify);
        int            accepted;
        int            wCyc;
        int            doneCyc;
        int            curAddr;
        int            nextAddr;
        bit            expWr;
        bit            nextWr;
        bit            rdExp;
        bit            ok;
        bit            ended;
        bit            validNow;
        logic [DW-1:0] sum;
        faultEn  = fault;
        ok       = !fault;
        accepted = 0;
        wCyc     = 0;
        doneCyc  = 0;
        curAddr  = 0;
        nextAddr = 0;
        expWr    = 1'b0;
        ended    = 1'b0;
        sum      = '0;
        @(negedge clock);
        start   = 1'b1;
        inValid = 1'b0;
        for (int cyc = 1; cyc <= 200 && !ended; cyc++) begin
            @(negedge clock);
            start = (cyc == midStart);
            rdExp = (wCyc > 0) && (cyc > wCyc) && (cyc <= wCyc + DEPTH);
            checkOutput("in_ready", inReadyA, (accepted < DEPTH) ? 32'd1 : 32'd0);
            checkOutput("lut_wren", wrenA, 32'(expWr));
            if (expWr) begin
                checkOutput("wr_addr", addrA, 32'(curAddr));
                checkOutput("wr_data", dataA, words[curAddr]);
            end
            checkOutput("lut_rden", rdenA, 32'(rdExp));
            if (rdExp) checkOutput("rd_addr", addrA, 32'(cyc - wCyc - 1));
            checkOutput("wren_rden_excl", wrenA & rdenA, 32'd0);
            checkOutput("checksum_run", checksumA, sum);
            checkOutput("busy", busyA, 32'((doneCyc == 0) || (cyc < doneCyc)));
            checkOutput("done", doneA, 32'(ok && doneCyc > 0 && cyc >= doneCyc));
            checkOutput("error", errorA, 32'(!ok && doneCyc > 0 && cyc >= doneCyc));
            checkOutput("lut_rden_B", rdenB, 32'(rdExp));
            checkOutput("busy_B", busyB, 32'((doneCyc == 0) || (cyc < doneCyc + 1)));
            checkOutput("done_B", doneB, 32'(ok && doneCyc > 0 && cyc >= doneCyc + 1));
            checkOutput("error_B", errorB, 32'(!ok && doneCyc > 0 && cyc >= doneCyc + 1));

            if (abortVerify && wCyc > 0 && cyc == wCyc + 3) begin
                rstN = 1'b0;
                #1;
                checkOutput("abort_rden", rdenA, 32'd0);
                checkOutput("abort_busy", busyA, 32'd0);
                checkOutput("abort_in_ready", inReadyA, 32'd0);
                checkOutput("abort_checksum", checksumA, 32'd0);
                checkOutput("abort_rden_B", rdenB, 32'd0);
                @(negedge clock);
                rstN  = 1'b1;
                ended = 1'b1;
            end else if (doneCyc > 0 && cyc == doneCyc + 1) begin
                checkOutput("final_checksum_B", checksumB, sum);
                ended = 1'b1;
            end else begin
                case (validMode)
                    0:       validNow = 1'b1;
                    1:       validNow = (cyc % 2 == 0);
                    default: validNow = 1'($urandom_range(0, 1));
                endcase
                nextWr = 1'b0;
                if (accepted < DEPTH) begin
                    inValid = validNow;
                    inData  = validNow ? words[accepted] : $urandom;
                    if (validNow) begin
                        nextWr   = 1'b1;
                        nextAddr = accepted;
                        sum      = sum + words[accepted];
                        accepted++;
                        if (accepted == DEPTH) begin
                            wCyc    = cyc + 1;
                            doneCyc = wCyc + DEPTH + 1 + 1;
                        end
                    end
                end else begin
                    inValid = 1'b1;
                    inData  = $urandom;
                end
                expWr   = nextWr;
                curAddr = nextAddr;
            end
        end
        checkOutput("run_completed", 32'(ended), 32'd1);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rstN    = 1'b0;
        start   = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        faultEn = 1'b0;
        #12;
        checkOutput("rst_in_ready", inReadyA, 32'd0);
        checkOutput("rst_wren", wrenA, 32'd0);
        checkOutput("rst_rden", rdenA, 32'd0);
        checkOutput("rst_busy", busyA, 32'd0);
        checkOutput("rst_done", doneA, 32'd0);
        checkOutput("rst_error", errorA, 32'd0);
        checkOutput("rst_address", addrA, 32'd0);
        checkOutput("rst_data", dataA, 32'd0);
        checkOutput("rst_checksum", checksumA, 32'd0);
        checkOutput("rst_busy_B", busyB, 32'd0);

        @(negedge clock);
        rstN = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("idle_in_ready", inReadyA, 32'd0);
        checkOutput("idle_busy", busyA, 32'd0);

        $display("[TB] back-to-back load of words 1..8");
        for (int i = 0; i < DEPTH; i++) words[i] = 32'(i + 1);
        applyStimulus(0, 1'b0, 0, 1'b0);
        checkOutput("checksum_36", checksumA, 32'd36);

        $display("[TB] bursty source with start pulsed mid-load, reloading from done");
        applyStimulus(1, 1'b0, 3, 1'b0);
        checkOutput("bursty_checksum_36", checksumA, 32'd36);

        $display("[TB] readback fault at address 3");
        applyStimulus(0, 1'b1, 0, 1'b0);
        checkOutput("fault_error", errorA, 32'd1);
        checkOutput("fault_done", doneA, 32'd0);
        checkOutput("fault_checksum", checksumA, 32'd36);

        $display("[TB] wrap-around with all-ones words");
        for (int i = 0; i < DEPTH; i++) words[i] = 32'hFFFF_FFFF;
        applyStimulus(0, 1'b0, 0, 1'b0);
        checkOutput("wrap_checksum", checksumA, 32'hFFFF_FFF8);

        $display("[TB] random words and random valid gaps");
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
            applyStimulus(2, 1'b0, 0, 1'b0);
        end

        $display("[TB] asynchronous reset during verify, then reload");
        applyStimulus(0, 1'b0, 0, 1'b1);
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        applyStimulus(0, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
